sensor_frame_assembler: RTL



---
 rtl/sensor_frame_assembler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sensor_frame_assembler.sv
// Deserialises parity-protected status frames from the sensor bus and hands
// good words to the status-word memory register; bad or stalled frames are counted.
module sensor_frame_assembler #(
    parameter int DATA_W   = 35,
    parameter int TIMEOUT  = 16,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                sof,
    input  logic                bit_valid,
    input  logic                bit_in,
    input  logic                err_clr,
    output logic                wren,
    output logic [DATA_W-1:0]   din,
    output logic                busy,
    output logic                frame_err,
    output logic [ERRCNT_W-1:0] err_count
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W);
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(TIMEOUT);
    localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic                  wren_q, wren_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

    logic                  start;
    logic [CNT_W-1:0]      cnt_next;
    logic [GAP_W-1:0]      gap_next;

    assign start    = sof & bit_valid;
    assign cnt_next = cnt_q + CNT_W'(1);
    assign gap_next = gap_q + GAP_W'(1);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        din_d       = din_q;
        wren_d      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {{(DATA_W-1){1'b0}}, bit_in};
                    par_d   = bit_in;
                    cnt_d   = CNT_W'(1);
                    gap_d   = '0;
                    state_d = DATA;
                end
            end
            DATA, PARITY: begin
                if (start) begin
                    // A new sof pre-empts the frame in flight; its bit opens the next frame.
                    frame_err_d = 1'b1;
                    shift_d     = {{(DATA_W-1){1'b0}}, bit_in};
                    par_d       = bit_in;
                    cnt_d       = CNT_W'(1);
                    gap_d       = '0;
                    state_d     = DATA;
                end else if (bit_valid) begin
                    gap_d = '0;
                    if (state_q == DATA) begin
                        shift_d = {shift_q[DATA_W-2:0], bit_in};
                        par_d   = par_q ^ bit_in;
                        cnt_d   = cnt_next;
                        if (cnt_next == CNT_LAST) begin
                            state_d = PARITY;
                        end
                    end else begin
                        if ((par_q ^ bit_in) == 1'b0) begin
                            din_d  = shift_q;
                            wren_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (gap_next == GAP_LAST) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    gap_d       = '0;
                    state_d     = IDLE;
                end else begin
                    gap_d = gap_next;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Clear takes priority over a coincident increment.
        if (err_clr) begin
            err_count_d = '0;
        end else if (frame_err_d && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            gap_q       <= '0;
            din_q       <= '0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            din_q       <= din_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign wren      = wren_q;
    assign din       = din_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
endmodule
